pe_accumulator: RTL and testbench

- Downstream stage of the approximate multiplier in each APTPU processing element.
- Consumes unsigned products of width DW+WW, one per handshake, and accumulates exactly K of them into an ACC_W-bit sum.
- Presents the finished dot-product partial sum on a valid/ready output port.
- Supports saturating or wrap-around accumulation, with a sticky overflow flag.

---
 rtl/aptpu_pkg.sv | 18 +
 rtl/pe_accumulator_if.sv | 32 +++
 rtl/pe_sat_adder.sv | 22 ++
 rtl/pe_accumulator.sv | 103 ++++++++++
 tb/tb_pe_accumulator.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/aptpu_pkg.sv
// Shared definitions for the APTPU processing-element datapath: FSM state
// encodings, the default accumulator width and the operand-width sanity check.
package aptpu_pkg;

  localparam int ACC_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } pe_state_t;

  // The accumulator must be wide enough to hold a single full product.
  function automatic bit acc_width_ok(input int acc_w, input int dw, input int ww);
    return acc_w >= dw + ww;
  endfunction

endpackage

// File: rtl/pe_accumulator_if.sv
// Product-in / partial-sum-out handshake bundle of a processing-element accumulator.
interface pe_accumulator_if
  import aptpu_pkg::*;
#(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int KW    = 16
);

  logic             start;
  logic [KW-1:0]    k_len;
  logic [DW+WW-1:0] prod_in;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic             ovf;
  logic             busy;

  modport master (
    output start, k_len, prod_in, prod_valid, acc_ready,
    input  prod_ready, acc_out, acc_valid, ovf, busy
  );

  modport slave (
    input  start, k_len, prod_in, prod_valid, acc_ready,
    output prod_ready, acc_out, acc_valid, ovf, busy
  );

endinterface

// File: rtl/pe_sat_adder.sv
// Combinational accumulate step: zero-extends the addend, adds it one bit wider
// than the accumulator and either clamps to all-ones or wraps on carry-out.
module pe_sat_adder
  import aptpu_pkg::*;
#(
  parameter int IW       = 16,
  parameter int ACC_W    = ACC_W_DEFAULT,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IW-1:0]    addend,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, acc} + {{(ACC_W + 1 - IW){1'b0}}, addend};
  assign carry    = full_sum[ACC_W];
  assign sum      = ((SATURATE != 0) && carry) ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];

endmodule

// File: rtl/pe_accumulator.sv
// Accumulates exactly k_len unsigned products into one partial sum and offers
// it on a valid/ready port, with a sticky overflow flag per accumulation.
module pe_accumulator
  import aptpu_pkg::*;
#(
  parameter int DW       = 8,
  parameter int WW       = 8,
  parameter int ACC_W    = ACC_W_DEFAULT,
  parameter int SATURATE = 1,
  parameter int KW       = 16
) (
  input  logic               clk,
  input  logic               rst,
  pe_accumulator_if.slave    bus
);

  localparam int IW = DW + WW;

  if (!acc_width_ok(ACC_W, DW, WW)) begin : g_bad_acc_width
    $error("pe_accumulator: ACC_W must be at least DW+WW");
  end

  pe_state_t        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [KW-1:0]    count_q, count_d;
  logic [KW-1:0]    k_q, k_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             handshake;

  pe_sat_adder #(
    .IW       (IW),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_adder (
    .acc    (acc_q),
    .addend (bus.prod_in),
    .sum    (add_sum),
    .carry  (add_carry)
  );

  // Every output is a decode of registered state, so nothing downstream sees prod_in or acc_ready combinationally.
  assign bus.prod_ready = (state_q == ST_ACCUM);
  assign bus.acc_valid  = (state_q == ST_DONE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.acc_out    = acc_q;
  assign bus.ovf        = ovf_q;
  assign handshake      = bus.prod_valid & bus.prod_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          k_d     = bus.k_len;
          state_d = (bus.k_len != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        if (handshake) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_carry;
          count_d = count_q + KW'(1);
          if (count_q == k_q - KW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.acc_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      k_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pe_accumulator.sv
// Drives three accumulators (32-bit saturating, 16-bit saturating, 16-bit wrap)
// with identical stimulus and compares each against an arithmetic reference.
module tb_pe_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] k_len;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic        acc_ready;

  int unsigned prods[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pe_accumulator_if #(.DW(8), .WW(8), .ACC_W(32), .KW(16)) if_a ();
  pe_accumulator_if #(.DW(8), .WW(8), .ACC_W(16), .KW(16)) if_s ();
  pe_accumulator_if #(.DW(8), .WW(8), .ACC_W(16), .KW(16)) if_w ();

  assign if_a.start = start;      assign if_s.start = start;      assign if_w.start = start;
  assign if_a.k_len = k_len;      assign if_s.k_len = k_len;      assign if_w.k_len = k_len;
  assign if_a.prod_in = prod_in;  assign if_s.prod_in = prod_in;  assign if_w.prod_in = prod_in;
  assign if_a.prod_valid = prod_valid;
  assign if_s.prod_valid = prod_valid;
  assign if_w.prod_valid = prod_valid;
  assign if_a.acc_ready = acc_ready;
  assign if_s.acc_ready = acc_ready;
  assign if_w.acc_ready = acc_ready;

  pe_accumulator #(.DW(8), .WW(8), .ACC_W(32), .SATURATE(1), .KW(16))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  pe_accumulator #(.DW(8), .WW(8), .ACC_W(16), .SATURATE(1), .KW(16))
    dut_s (.clk(clk), .rst(rst), .bus(if_s));
  pe_accumulator #(.DW(8), .WW(8), .ACC_W(16), .SATURATE(0), .KW(16))
    dut_w (.clk(clk), .rst(rst), .bus(if_w));

  // Reference: running sum of the queued products, clamped or wrapped at 2^acc_w.
  function automatic void model_run(input int acc_w, input bit sat,
                                    output logic [63:0] sum, output logic [63:0] ovf);
    longint lim = longint'(1) << acc_w;
    longint s   = 0;
    ovf = 0;
    foreach (prods[i]) begin
      s += longint'(prods[i]);
      if (s >= lim) begin
        ovf = 1;
        s   = sat ? lim - 1 : s - lim;
      end
    end
    sum = 64'(s);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_a_out"},   64'(if_a.acc_out),    0);
    checkOutput({tag, "_a_valid"}, 64'(if_a.acc_valid),  0);
    checkOutput({tag, "_a_ready"}, 64'(if_a.prod_ready), 0);
    checkOutput({tag, "_a_ovf"},   64'(if_a.ovf),        0);
    checkOutput({tag, "_a_busy"},  64'(if_a.busy),       0);
    checkOutput({tag, "_s_out"},   64'(if_s.acc_out),    0);
    checkOutput({tag, "_s_busy"},  64'(if_s.busy),       0);
    checkOutput({tag, "_w_out"},   64'(if_w.acc_out),    0);
    checkOutput({tag, "_w_valid"}, 64'(if_w.acc_valid),  0);
  endtask

  task automatic check_done(input string tag);
    logic [63:0] e_sum, e_ovf;
    model_run(32, 1'b1, e_sum, e_ovf);
    checkOutput({tag, "_a_valid"}, 64'(if_a.acc_valid),  1);
    checkOutput({tag, "_a_ready"}, 64'(if_a.prod_ready), 0);
    checkOutput({tag, "_a_busy"},  64'(if_a.busy),       1);
    checkOutput({tag, "_a_out"},   64'(if_a.acc_out),    e_sum);
    checkOutput({tag, "_a_ovf"},   64'(if_a.ovf),        e_ovf);
    model_run(16, 1'b1, e_sum, e_ovf);
    checkOutput({tag, "_s_valid"}, 64'(if_s.acc_valid),  1);
    checkOutput({tag, "_s_out"},   64'(if_s.acc_out),    e_sum);
    checkOutput({tag, "_s_ovf"},   64'(if_s.ovf),        e_ovf);
    model_run(16, 1'b0, e_sum, e_ovf);
    checkOutput({tag, "_w_valid"}, 64'(if_w.acc_valid),  1);
    checkOutput({tag, "_w_out"},   64'(if_w.acc_out),    e_sum);
    checkOutput({tag, "_w_ovf"},   64'(if_w.ovf),        e_ovf);
  endtask

  // One complete job: start, feed the queued products, then hold and release the result.
  task automatic applyStimulus(input int gap, input int hold, input bit pulse);
    acc_ready = (hold == 0);
    start = 1'b1;
    k_len = 16'(prods.size());
    step();
    start = 1'b0;
    for (int i = 0; i < prods.size(); i++) begin
      checkOutput("accum_ready", 64'(if_a.prod_ready), 1);
      checkOutput("accum_valid", 64'(if_a.acc_valid),  0);
      prod_valid = 1'b1;
      prod_in    = 16'(prods[i]);
      step();
      prod_valid = 1'b0;
      if (i != prods.size() - 1) begin
        for (int g = 0; g < gap; g++) begin
          start = pulse;
          step();
        end
      end
      start = 1'b0;
    end
    check_done("done");
    for (int h = 0; h < hold; h++) begin
      start = pulse;
      step();
      check_done("hold");
    end
    acc_ready = 1'b1;
    start = pulse;
    step();
    start = 1'b0;
    checkOutput("release_valid", 64'(if_a.acc_valid), 0);
    checkOutput("release_busy",  64'(if_a.busy),      0);
    checkOutput("release_busy_w", 64'(if_w.busy),     0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; prod_in = '0; prod_valid = 1'b0; acc_ready = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    $display("[TB] basic run");
    prods = '{10, 20, 30, 40};
    applyStimulus(0, 0, 1'b0);

    $display("[TB] gaps and backpressure");
    prods = '{5, 7, 9};
    applyStimulus(2, 5, 1'b1);

    $display("[TB] zero length");
    prods.delete();
    applyStimulus(0, 1, 1'b0);

    $display("[TB] overflow then sticky-flag clear");
    prods = '{65025, 65025};
    applyStimulus(0, 0, 1'b0);
    prods = '{3};
    applyStimulus(0, 0, 1'b0);

    $display("[TB] reset mid-operation");
    acc_ready  = 1'b1;
    start      = 1'b1;
    k_len      = 16'd4;
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod_in    = 16'd60000;
    step();
    prod_in    = 16'd50000;
    step();
    prod_valid = 1'b0;
    rst        = 1'b1;
    step();
    rst        = 1'b0;
    check_all_zero("midreset");
    prods = '{9};
    applyStimulus(0, 0, 1'b0);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 25; j++) begin
      int k;
      prods.delete();
      k = int'($urandom_range(1, 6));
      for (int i = 0; i < k; i++) begin
        if ($urandom_range(0, 2) == 0) prods.push_back(65025 - $urandom_range(0, 200));
        else                           prods.push_back($urandom_range(0, 40000));
      end
      applyStimulus(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
